md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Execute-stage multiply/divide unit; sits beside the ALU and takes the same forwarded E-stage operands.
//  Runs mult/multu/div/divu over several cycles and holds the architectural HI/LO registers.
//  Also executes mthi/mtlo and provides HI/LO for mfhi/mflo.
//  Exports busy/start so the hazard unit can drive the fetch freeze while an MD instruction is pending.
// PARAMETERS
//  MULT_CYCLES  5   busy duration for mult/multu; legal range 1..15
//  DIV_CYCLES   10  busy duration for div/divu; legal range 1..15
// PORTS
//  clk      in   1   clock, all state updates on rising edge
//  reset    in   1   synchronous, active-high reset
//  md_op    in   4   0=none 1=mult 2=multu 3=div 4=divu 5=mthi 6=mtlo 7..15=none
//  start    in   1   E-stage MD instruction valid this cycle (qualifies md_op)
//  A        in   32  operand rs (forwarded)
//  B        in   32  operand rt (forwarded)
//  hi       out  32  current HI register
//  lo       out  32  current LO register
//  busy     out  1   multi-cycle operation in progress
// BEHAVIOUR
//  Reset (clk edge with reset=1): hi=0, lo=0, busy=0, internal counter=0, latched operands=0.
//   Reset wins over every other input, including a pending operation, which is discarded.
//  Accept: on an edge with start=1, busy=0 and md_op in 1..4:
//   - A, B, md_op are latched.
//   - counter <= MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
//   - busy <= 1.
//  Run: on each edge with busy=1:
//   - counter <= counter-1.
//   - When counter==1: hi/lo <= result and busy <= 0 on that same edge.
//   - busy is therefore high for exactly N cycles after the accept edge.
//   - New hi/lo are visible in the first cycle with busy=0.
//  Results:
//   - mult:  {hi,lo} = signed(A)*signed(B), 64 bit.
//   - multu: {hi,lo} = unsigned product, 64 bit.
//   - div:   lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
//   - divu:  lo = unsigned quotient; hi = unsigned remainder.
//   - Divide by zero (B==0, div or divu): hi/lo keep their prior values; busy timing is unchanged.
//   - div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
//  mthi/mtlo:
//   - On an edge with start=1, busy=0, md_op=5: hi <= A.
//   - On an edge with start=1, busy=0, md_op=6: lo <= A.
//   - Single cycle; busy is not asserted.
//  start=1 while busy=1: ignored completely; no state change. The hazard unit must stall so this never happens.
//  start=0, or md_op 0 or 7..15: no state change.
//  hi/lo read combinationally from the registers; during busy they show the pre-operation values.
//  Hazard contract: the D-stage MD instruction (including mfhi/mflo) is stalled while (busy | start).
//   The unit provides busy; the hazard unit combines it with start.
// TESTING
//  1 reset, then mult A=0xFFFFFFFE(-2) B=3 -> busy high 5 cycles; then hi=0xFFFFFFFF lo=0xFFFFFFFA.
//  2 multu A=0xFFFFFFFF B=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE lo=0x00000001.
//  3 div A=0xFFFFFFF9(-7) B=2 -> busy 10 cycles; lo=0xFFFFFFFD(-3) hi=0xFFFFFFFF(-1).
//    Then divu A=7 B=0 -> busy 10 cycles; hi/lo unchanged.
//  4 mthi A=0x12345678 then mtlo A=0x9ABCDEF0 on consecutive cycles -> hi/lo updated the next cycle, busy stays 0.
//    Then start mult while busy -> second start ignored; result equals first op only.
//  5 start div A=100 B=7, assert reset in busy cycle 4 -> next cycle busy=0, hi=lo=0; no late writeback.
//  6 back-to-back: start multu 6*7, then start mult in the first busy=0 cycle -> first result lo=42 is visible.
//    Second op is accepted and completes normally.

Source files
------------

// File: rtl/md_unit.sv
// ============================================================================
// Module      : md_unit
// Description : Execute-stage multiply/divide unit holding the HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  localparam logic [3:0] c_OP_MULT  = 4'd1;
  localparam logic [3:0] c_OP_MULTU = 4'd2;
  localparam logic [3:0] c_OP_DIV   = 4'd3;
  localparam logic [3:0] c_OP_DIVU  = 4'd4;
  localparam logic [3:0] c_OP_MTHI  = 4'd5;
  localparam logic [3:0] c_OP_MTLO  = 4'd6;

  logic [31:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
  logic [3:0]  op_q, op_d, cnt_q, cnt_d;
  logic        busy_q, busy_d;

  logic [63:0] w_prod_s, w_prod_u;
  logic        w_neg_a, w_neg_b, w_div_signed;
  logic [31:0] w_mag_a, w_mag_b, w_den, w_quo_u, w_rem_u, w_quo, w_rem;

  assign w_prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign w_prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide is done on magnitudes so 0x80000000/-1 and rounding are explicit.
  assign w_div_signed = (op_q == c_OP_DIV);
  assign w_neg_a      = w_div_signed & a_q[31];
  assign w_neg_b      = w_div_signed & b_q[31];
  assign w_mag_a      = w_neg_a ? (~a_q + 32'd1) : a_q;
  assign w_mag_b      = w_neg_b ? (~b_q + 32'd1) : b_q;
  assign w_den        = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
  assign w_quo_u      = w_mag_a / w_den;
  assign w_rem_u      = w_mag_a % w_den;
  assign w_quo        = (w_neg_a ^ w_neg_b) ? (~w_quo_u + 32'd1) : w_quo_u;
  assign w_rem        = w_neg_a ? (~w_rem_u + 32'd1) : w_rem_u;

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (busy_q) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        case (op_q)
          c_OP_MULT:  {hi_d, lo_d} = w_prod_s;
          c_OP_MULTU: {hi_d, lo_d} = w_prod_u;
          c_OP_DIV, c_OP_DIVU: begin
            if (b_q != 32'd0) begin
              hi_d = w_rem;
              lo_d = w_quo;
            end
          end
          default: ;
        endcase
      end
    end else if (start) begin
      case (md_op)
        c_OP_MULT, c_OP_MULTU, c_OP_DIV, c_OP_DIVU: begin
          a_d    = A;
          b_d    = B;
          op_d   = md_op;
          busy_d = 1'b1;
          cnt_d  = (md_op == c_OP_DIV || md_op == c_OP_DIVU) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end
        c_OP_MTHI: hi_d = A;
        c_OP_MTLO: lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      op_q   <= 4'd0;
      cnt_q  <= 4'd0;
      busy_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// Module      : tb_md_unit
// Description : Directed self-checking bench for md_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic        start;
  logic [31:0] A, B;
  logic [31:0] hi, lo;
  logic        busy;

  int checks = 0;
  int errors = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .start(start),
    .A(A), .B(B), .hi(hi), .lo(lo), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; A = a; B = b;
    tick();
    start = 1'b0; md_op = 4'd0;
  endtask

  // Counts edges until busy falls; returns 99 if it never does.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) n = 99;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; md_op = 4'd0; A = 32'd0; B = 32'd0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
  endtask

  task automatic test_mult();
    int n;
    issue(4'd1, 32'hFFFFFFFE, 32'd3);
    checks++; if (busy !== 1'b1 || hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL mult_during busy=%b hi=%h lo=%h exp 1/0/0", busy, hi, lo); end
    wait_idle(n);
    checks++; if (n != 5) begin errors++; $display("FAIL mult_busy_cycles got %0d exp 5", n); end
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_result got %h_%h exp ffffffff_fffffffa", hi, lo); end
  endtask

  task automatic test_multu();
    int n;
    issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(n);
    checks++; if (n != 5) begin errors++; $display("FAIL multu_busy_cycles got %0d exp 5", n); end
    checks++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin errors++; $display("FAIL multu_result got %h_%h exp fffffffe_00000001", hi, lo); end
  endtask

  task automatic test_div();
    int n;
    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    checks++; if (n != 10) begin errors++; $display("FAIL div_busy_cycles got %0d exp 10", n); end
    checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg got hi=%h lo=%h exp ffffffff/fffffffd", hi, lo); end
    issue(4'd4, 32'd7, 32'd0);
    wait_idle(n);
    checks++; if (n != 10) begin errors++; $display("FAIL divu_zero_cycles got %0d exp 10", n); end
    checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_zero_hold got hi=%h lo=%h exp ffffffff/fffffffd", hi, lo); end
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    checks++; if (lo !== 32'h80000000 || hi !== 32'd0) begin errors++; $display("FAIL div_overflow got hi=%h lo=%h exp 0/80000000", hi, lo); end
    issue(4'd3, 32'd7, 32'hFFFFFFFE);
    wait_idle(n);
    checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'd1) begin errors++; $display("FAIL div_negdivisor got hi=%h lo=%h exp 1/fffffffd", hi, lo); end
    issue(4'd4, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    checks++; if (lo !== 32'h7FFFFFFC || hi !== 32'd1) begin errors++; $display("FAIL divu_big got hi=%h lo=%h exp 1/7ffffffc", hi, lo); end
    issue(4'd3, 32'd5, 32'd0);
    wait_idle(n);
    checks++; if (lo !== 32'h7FFFFFFC || hi !== 32'd1) begin errors++; $display("FAIL div_zero_hold got hi=%h lo=%h exp 1/7ffffffc", hi, lo); end
  endtask

  task automatic test_mthi_mtlo();
    start = 1'b1; md_op = 4'd5; A = 32'h12345678; B = 32'd0;
    tick();
    checks++; if (hi !== 32'h12345678 || busy !== 1'b0) begin errors++; $display("FAIL mthi got hi=%h busy=%b exp 12345678/0", hi, busy); end
    md_op = 4'd6; A = 32'h9ABCDEF0;
    tick();
    start = 1'b0; md_op = 4'd0;
    checks++; if (lo !== 32'h9ABCDEF0 || hi !== 32'h12345678 || busy !== 1'b0) begin errors++; $display("FAIL mtlo got hi=%h lo=%h busy=%b exp 12345678/9abcdef0/0", hi, lo, busy); end
  endtask

  task automatic test_noop();
    start = 1'b1; md_op = 4'd7; A = 32'hDEADBEEF; B = 32'd1;
    tick();
    md_op = 4'd0;
    tick();
    start = 1'b0;
    md_op = 4'd5;
    tick();
    md_op = 4'd0;
    checks++; if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0 || busy !== 1'b0) begin errors++; $display("FAIL noop got hi=%h lo=%h busy=%b exp 12345678/9abcdef0/0", hi, lo, busy); end
  endtask

  task automatic test_busy_ignore();
    int n;
    issue(4'd1, 32'd3, 32'd4);
    start = 1'b1; md_op = 4'd2; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
    tick();
    md_op = 4'd5;
    tick();
    start = 1'b0; md_op = 4'd0;
    checks++; if (hi !== 32'h12345678 || busy !== 1'b1) begin errors++; $display("FAIL busy_ignore_mid got hi=%h busy=%b exp 12345678/1", hi, busy); end
    wait_idle(n);
    checks++; if (n != 3) begin errors++; $display("FAIL busy_ignore_cycles got %0d exp 3", n); end
    checks++; if (hi !== 32'd0 || lo !== 32'd12) begin errors++; $display("FAIL busy_ignore_result got %h_%h exp 00000000_0000000c", hi, lo); end
  endtask

  task automatic test_reset_abort();
    issue(4'd3, 32'd100, 32'd7);
    tick(); tick(); tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_precond busy got %b exp 1", busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL abort_reset got busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo); end
    for (int i = 0; i < 12; i++) tick();
    checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL abort_late got busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo); end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(4'd2, 32'd6, 32'd7);
    wait_idle(n);
    checks++; if (lo !== 32'd42 || hi !== 32'd0 || n != 5) begin errors++; $display("FAIL b2b_first got hi=%h lo=%h cycles=%0d exp 0/2a/5", hi, lo, n); end
    issue(4'd1, 32'hFFFFFFFB, 32'd4);
    checks++; if (busy !== 1'b1 || lo !== 32'd42) begin errors++; $display("FAIL b2b_accept got busy=%b lo=%h exp 1/2a", busy, lo); end
    wait_idle(n);
    checks++; if (n != 5 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEC) begin errors++; $display("FAIL b2b_second got hi=%h lo=%h cycles=%0d exp ffffffff/ffffffec/5", hi, lo, n); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_mthi_mtlo();
    test_noop();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

`default_nettype wire
